demux8_wb: RTL and testbench

DEMUX8_WB -- requirements
Module: demux8_wb

---
 rtl/demux8_wb_pkg.sv | 30 +++
 rtl/demux8_wb_fifo.sv | 83 ++++++++
 rtl/demux8_wb.sv | 119 +++++++++++
 tb/tb_demux8_wb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/demux8_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux8_wb_pkg
// Description : Shared constants and types for the demux8_wb write-back
//               demultiplexer: default data width, destination count and
//               index width, the packed staging entry and the FIFO state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package demux8_wb_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int NUM_DEST       = 8;
    localparam int DEST_W         = 3;

    // Staging entry as stored in the FIFO: destination index above the data.
    typedef struct packed {
        logic [DEST_W-1:0]         dest;
        logic [DATA_W_DEFAULT-1:0] data;
    } entry_t;

    // FIFO occupancy states; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/demux8_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux8_wb_fifo
// Description : Two-entry staging FIFO for demux8_wb. Entry 0 is always the
//               head; a pop from FULL shifts entry 1 forward.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset
//               i_push  - write i_din at the tail (ignored when full)
//               i_pop   - remove the head entry (ignored when empty)
//               i_din   - entry to push
//               o_head  - current head entry
//               o_count - occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module demux8_wb_fifo
    import demux8_wb_pkg::*;
#(
    parameter int WIDTH = DEST_W + DATA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    fifo_state_t      r_state;
    fifo_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic             w_push;
    logic             w_pop;

    // Self-protecting qualifiers so the storage can never over/underflow.
    assign w_push = i_push && (r_state != FIFO_FULL);
    assign w_pop  = i_pop  && (r_state != FIFO_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FIFO_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FIFO_EMPTY: if (w_push)            w_state_nxt = FIFO_ONE;
            FIFO_ONE: begin
                if (w_push && !w_pop)          w_state_nxt = FIFO_FULL;
                else if (w_pop && !w_push)     w_state_nxt = FIFO_EMPTY;
            end
            FIFO_FULL:  if (w_pop)             w_state_nxt = FIFO_ONE;
            default:                           w_state_nxt = FIFO_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            case (r_state)
                FIFO_EMPTY: if (w_push) r_ent0 <= i_din;
                FIFO_ONE: begin
                    // Simultaneous push and pop replaces the head in place.
                    if (w_push && w_pop)   r_ent0 <= i_din;
                    else if (w_push)       r_ent1 <= i_din;
                end
                FIFO_FULL:  if (w_pop)  r_ent0 <= r_ent1;
                default: ;
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_count = r_state;

endmodule
`default_nettype wire

// File: rtl/demux8_wb.sv
`default_nettype none
// ============================================================================
// Module      : demux8_wb
// Description : Write-back demultiplexer. Writes {in_dest, in_data} are
//               staged in a 2-entry FIFO and drained one per cycle (unless
//               hold is high) into one of eight destination registers, with
//               a registered one-hot update strobe.
// Ports       : clk, rst_n (async active-low)
//               in_valid/in_ready/in_dest/in_data - write request handshake
//               hold      - freeze draining
//               q0..q7    - destination registers
//               wr_strobe - one-hot pulse, bit i marks an update of qi
//               busy      - staging FIFO non-empty
// Config      : DEMUX8_WB_R0_ZERO_EN - destination 0 is hard-wired to zero;
//               its writes are consumed and dropped without a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module demux8_wb
    import demux8_wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [DATA_W-1:0] q3,
    output logic [DATA_W-1:0] q4,
    output logic [DATA_W-1:0] q5,
    output logic [DATA_W-1:0] q6,
    output logic [DATA_W-1:0] q7,
    output logic [7:0]        wr_strobe,
    output logic              busy
);

    localparam int         c_ENTRY_W = DEST_W + DATA_W;
    localparam logic [1:0] c_DEPTH   = 2'(FIFO_DEPTH);

    logic [1:0]           w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic [DEST_W-1:0]    w_head_dest;
    logic [DATA_W-1:0]    w_head_data;
    logic                 w_accept;
    logic                 w_drain;
    logic [NUM_DEST-1:0]  w_wr_en;
    logic [NUM_DEST-1:0]  r_strobe;
    logic [DATA_W-1:0]    r_q [NUM_DEST];

    // Readiness depends only on the current occupancy, so a full FIFO
    // refuses a write even on a cycle where it also drains.
    assign in_ready = (w_count < c_DEPTH);
    assign busy     = (w_count != 2'd0);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = busy && !hold;

    demux8_wb_fifo #(
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_drain),
        .i_din   ({in_dest, in_data}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign {w_head_dest, w_head_data} = w_head;

    always_comb begin
        w_wr_en = '0;
        if (w_drain) begin
            w_wr_en[w_head_dest] = 1'b1;
        end
`ifdef DEMUX8_WB_R0_ZERO_EN
        // Entry is still popped; only the register update is suppressed.
        w_wr_en[0] = 1'b0;
`endif
    end

    generate
        for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q[i] <= '0;
                end else if (w_wr_en[i]) begin
                    r_q[i] <= w_head_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_wr_en;
        end
    end

    assign wr_strobe = r_strobe;
    assign q0 = r_q[0];
    assign q1 = r_q[1];
    assign q2 = r_q[2];
    assign q3 = r_q[3];
    assign q4 = r_q[4];
    assign q5 = r_q[5];
    assign q6 = r_q[6];
    assign q7 = r_q[7];

endmodule
`default_nettype wire

// File: tb/tb_demux8_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux8_wb
// Description : Self-checking bench for demux8_wb. A queue-based reference
//               model tracks pending writes and destination values; directed
//               scenarios are followed by randomized traffic.
// Config      : honours DEMUX8_WB_R0_ZERO_EN in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux8_wb;

    localparam int DW = 16;

    typedef struct packed {
        logic [2:0]    dest;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_dest = 3'd0;
    logic [DW-1:0] in_data = '0;
    logic          hold = 1'b0;
    logic [DW-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]    wr_strobe;
    logic          busy;

    always #5 clk = ~clk;

    demux8_wb #(
        .DATA_W     (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .hold      (hold),
        .q0        (q0),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .q4        (q4),
        .q5        (q5),
        .q6        (q6),
        .q7        (q7),
        .wr_strobe (wr_strobe),
        .busy      (busy)
    );

    int            checks = 0;
    int            errors = 0;
    ent_t          m_fifo[$];
    logic [DW-1:0] m_q [8];
    logic [7:0]    m_strobe;

    function automatic logic [DW-1:0] dut_q(input int i);
        case (i)
            0: return q0;
            1: return q1;
            2: return q2;
            3: return q3;
            4: return q4;
            5: return q5;
            6: return q6;
            default: return q7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, " in_ready"}, 32'(in_ready), 32'(m_fifo.size() < 2));
        check({ctx, " busy"}, 32'(busy), 32'(m_fifo.size() != 0));
        check({ctx, " wr_strobe"}, 32'(wr_strobe), 32'(m_strobe));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s q%0d", ctx, i), 32'(dut_q(i)), 32'(m_q[i]));
        end
    endtask

    function automatic bit r0_zero();
`ifdef DEMUX8_WB_R0_ZERO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive at the falling edge, model the rising edge from the
    // pre-edge queue, then compare just after the edge.
    task automatic cycle(input string ctx, input logic v, input logic [2:0] d,
                         input logic [DW-1:0] x, input logic h);
        bit   acc;
        bit   drn;
        ent_t e;
        in_valid = v;
        in_dest  = d;
        in_data  = x;
        hold     = h;
        acc = v && (m_fifo.size() < 2);
        drn = (m_fifo.size() > 0) && !h;
        @(posedge clk);
        #1;
        m_strobe = 8'h00;
        if (drn) begin
            e = m_fifo.pop_front();
            if (!(r0_zero() && e.dest == 3'd0)) begin
                m_q[e.dest] = e.data;
                m_strobe[e.dest] = 1'b1;
            end
        end
        if (acc) m_fifo.push_back('{dest: d, data: x});
        check_all(ctx);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        for (int i = 0; i < 8; i++) m_q[i] = '0;
        m_strobe = 8'h00;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Single write, first edge after reset, latency of one edge.
        cycle("w5 acc", 1'b1, 3'd5, 16'hA5A5, 1'b0);
        cycle("w5 drn", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("w5 q5 lit", 32'(q5), 32'h0000A5A5);
        check("w5 strobe lit", 32'(wr_strobe), 32'h20);
        cycle("w5 idle", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("w5 strobe clr", 32'(wr_strobe), 32'h0);

        // Hold: fill, observe full, release and drain in order.
        cycle("h acc1", 1'b1, 3'd1, 16'h1111, 1'b1);
        cycle("h acc2", 1'b1, 3'd2, 16'h2222, 1'b1);
        cycle("h stall", 1'b1, 3'd7, 16'h7777, 1'b1);
        check("h in_ready lit", 32'(in_ready), 32'h0);
        check("h busy lit", 32'(busy), 32'h1);
        cycle("h rel1", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("h q1 lit", 32'(q1), 32'h1111);
        cycle("h rel2", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("h q2 lit", 32'(q2), 32'h2222);

        // Back-to-back to the same destination; last one wins.
        cycle("b2b a", 1'b1, 3'd3, 16'h0001, 1'b0);
        cycle("b2b b", 1'b1, 3'd3, 16'h0002, 1'b0);
        check("b2b strobe1", 32'(wr_strobe), 32'h08);
        cycle("b2b c", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("b2b strobe2", 32'(wr_strobe), 32'h08);
        check("b2b q3 lit", 32'(q3), 32'h0002);

        // Full with valid held: no accept on the drain edge.
        cycle("full f1", 1'b1, 3'd4, 16'h4444, 1'b1);
        cycle("full f2", 1'b1, 3'd6, 16'h6666, 1'b1);
        cycle("full drn", 1'b1, 3'd7, 16'h7A7A, 1'b0);
        check("full cnt1 ready", 32'(in_ready), 32'h1);
        cycle("full acc", 1'b1, 3'd7, 16'h7B7B, 1'b1);
        check("full cnt2 ready", 32'(in_ready), 32'h0);

        // Reset with two entries pending.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("postrst 1", 1'b0, 3'd0, 16'h0000, 1'b0);
        cycle("postrst 2", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("postrst strobe", 32'(wr_strobe), 32'h0);

        // Destination 0 write (discarded when the zero-register option is on).
        cycle("d0 acc", 1'b1, 3'd0, 16'hFFFF, 1'b0);
        cycle("d0 drn", 1'b0, 3'd0, 16'h0000, 1'b0);
        check("d0 busy", 32'(busy), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  DW'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
